// File: rtl/fifo_skew_scheduler_if.sv
// fifo_skew_scheduler_if
// Bundles the control and status signals of the skew scheduler.
//   master : drives start, k_len, fifo_empty; observes read, valid, busy, done, error
//   slave  : the scheduler itself (mirror of master)
// Parameters must match the ones given to the scheduler instance.
interface fifo_skew_scheduler_if #(
    parameter int NUM_FIFOS = 4,
    parameter int CNT_WIDTH = 5
);
    logic                 start;
    logic [CNT_WIDTH-1:0] k_len;
    logic [NUM_FIFOS-1:0] fifo_empty;
    logic [NUM_FIFOS-1:0] read;
    logic [NUM_FIFOS-1:0] valid;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output start, k_len, fifo_empty,
        input  read, valid, busy, done, error
    );

    modport slave (
        input  start, k_len, fifo_empty,
        output read, valid, busy, done, error
    );
endinterface

// File: rtl/fifo_skew_scheduler.sv
// fifo_skew_scheduler
// Drains NUM_FIFOS input FIFOs into a systolic array edge with a diagonal skew:
// lane i reads K words starting i cycles after lane 0. If any lane that needs
// data this cycle is empty, every lane holds so the diagonal stays intact.
// A run of TIMEOUT consecutive stalled cycles aborts with a sticky error.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave modport carrying start/k_len/fifo_empty in and
//           read/valid/busy/done/error out
module fifo_skew_scheduler #(
    parameter int NUM_FIFOS = 4,
    parameter int CNT_WIDTH = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_skew_scheduler_if.slave bus
);
    // Step counter is wide enough to reach K+NUM_FIFOS-2 without wrapping.
    localparam int TW = CNT_WIDTH + $clog2(NUM_FIFOS + 1) + 1;
    localparam int SW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_k;
    logic [TW-1:0]        r_t;
    logic [SW-1:0]        r_stallCnt;
    logic [NUM_FIFOS-1:0] r_valid;
    logic                 r_error;

    logic [NUM_FIFOS-1:0] w_need;
    logic [NUM_FIFOS-1:0] w_read;
    logic [TW-1:0]        w_lastT;
    logic                 w_run;
    logic                 w_stall;
    logic                 w_last;
    logic                 w_timeout;
    logic                 w_accept;

    // Lane i is active on the window i <= t < i+K of the wavefront.
    always_comb begin
        w_need = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            w_need[i] = (r_t >= TW'(i)) && (r_t < (TW'(i) + TW'(r_k)));
        end
    end

    assign w_run     = (r_state == S_RUN);
    assign w_stall   = w_run && ((w_need & bus.fifo_empty) != '0);
    assign w_read    = (w_run && !w_stall) ? w_need : '0;
    assign w_lastT   = TW'(r_k) + TW'(NUM_FIFOS) - TW'(2);
    assign w_last    = (r_t == w_lastT);
    // This stalled cycle is the TIMEOUT-th in a row.
    assign w_timeout = w_stall && (r_stallCnt == SW'(TIMEOUT - 1));
    assign w_accept  = bus.start && (bus.k_len != '0);

    assign bus.read  = w_read;
    assign bus.valid = r_valid;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.error = r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_t        <= '0;
            r_stallCnt <= '0;
            r_valid    <= '0;
            r_error    <= 1'b0;
        end else begin
            r_valid <= w_read;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_k        <= bus.k_len;
                        r_t        <= '0;
                        r_stallCnt <= '0;
                        r_error    <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_stall) begin
                        if (w_timeout) begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_stallCnt <= r_stallCnt + SW'(1);
                        end
                    end else begin
                        r_stallCnt <= '0;
                        r_t        <= r_t + TW'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_skew_scheduler.sv
// tb_fifo_skew_scheduler
// Drives the scheduler through the interface and compares every cycle against
// a reference model that tracks the wavefront step, per-lane windows and the
// stall/timeout rules directly.
module tb_fifo_skew_scheduler;
    localparam int N  = 4;
    localparam int CW = 5;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_skew_scheduler_if #(.NUM_FIFOS(N), .CNT_WIDTH(CW)) bus ();

    fifo_skew_scheduler #(.NUM_FIFOS(N), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;

    int errors = 0;
    int checks = 0;

    mstate_t      mState;
    int           mK, mIdx, mStall;
    bit           mErr;
    logic [N-1:0] mValid;
    int           dutCount[N];
    int           busyCycles;
    int           runCycles;
    logic [N-1:0] readLog[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Lanes that hold live data at wavefront step s for vector length k.
    function automatic logic [N-1:0] wavefront(input int k, input int s);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = (s - i >= 0) && (s - i < k);
        return v;
    endfunction

    // One clock: drive inputs at negedge, check outputs, advance the model.
    task automatic applyStimulus(input logic st, input logic [CW-1:0] kl, input logic [N-1:0] emp);
        logic [N-1:0] need, expRead;
        bit stalled;
        @(negedge clk);
        bus.start = st;
        bus.k_len = kl;
        bus.fifo_empty = emp;
        #1;
        expRead = '0;
        stalled = 1'b0;
        if (mState == M_RUN) begin
            need = wavefront(mK, mIdx);
            stalled = ((need & emp) != '0);
            if (!stalled) expRead = need;
        end
        checkOutput("read", 32'(bus.read), 32'(expRead));
        checkOutput("valid", 32'(bus.valid), 32'(mValid));
        checkOutput("busy", 32'(bus.busy), 32'(mState != M_IDLE));
        checkOutput("done", 32'(bus.done), 32'(mState == M_DONE));
        checkOutput("error", 32'(bus.error), 32'(mErr));
        checkOutput("readOfEmpty", 32'(bus.read & emp), 32'(0));
        if (mState == M_RUN) begin
            readLog.push_back(bus.read);
            runCycles++;
        end
        if (bus.busy && !bus.done) busyCycles++;
        for (int i = 0; i < N; i++) dutCount[i] += int'(bus.read[i]);
        case (mState)
            M_IDLE: begin
                if (st && kl != '0) begin
                    mK = int'(kl);
                    mIdx = 0;
                    mStall = 0;
                    mErr = 1'b0;
                    mState = M_RUN;
                    busyCycles = 0;
                    runCycles = 0;
                    for (int i = 0; i < N; i++) dutCount[i] = 0;
                end
            end
            M_RUN: begin
                if (stalled) begin
                    mStall++;
                    if (mStall == TO) begin
                        mErr = 1'b1;
                        mState = M_IDLE;
                    end
                end else begin
                    mStall = 0;
                    if (mIdx == mK + N - 2) begin
                        mState = M_DONE;
                        for (int i = 0; i < N; i++) checkOutput("readsPerFifo", 32'(dutCount[i]), 32'(mK));
                    end
                    mIdx++;
                end
            end
            default: mState = M_IDLE;
        endcase
        mValid = expRead;
        @(posedge clk);
    endtask

    task automatic runToIdle(input logic [N-1:0] emp, input int limit);
        for (int c = 0; c < limit && mState != M_IDLE; c++) applyStimulus(1'b0, '0, emp);
        if (mState != M_IDLE) checkOutput("runBound", 32'(bus.busy), 32'(0));
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
    task automatic doReset();
        #1 reset = 1'b1;
        bus.start = 1'b0;
        #1;
        checkOutput("rstRead", 32'(bus.read), 32'(0));
        checkOutput("rstValid", 32'(bus.valid), 32'(0));
        checkOutput("rstBusy", 32'(bus.busy), 32'(0));
        checkOutput("rstDone", 32'(bus.done), 32'(0));
        checkOutput("rstError", 32'(bus.error), 32'(0));
        mState = M_IDLE;
        mErr = 1'b0;
        mValid = '0;
        mStall = 0;
        #1 reset = 1'b0;
    endtask

    task automatic checkBasicPattern(input string tag);
        logic [N-1:0] pat[6];
        pat = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
        readLog.delete();
        applyStimulus(1'b1, CW'(3), '0);
        runToIdle('0, 20);
        checkOutput({tag, "Len"}, 32'(readLog.size()), 32'(6));
        for (int j = 0; j < 6 && j < readLog.size(); j++) checkOutput(tag, 32'(readLog[j]), 32'(pat[j]));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] emp;
        logic [N-1:0] pat32[9];
        int injected;

        mState = M_IDLE; mK = 0; mIdx = 0; mStall = 0; mErr = 1'b0; mValid = '0;
        busyCycles = 0; runCycles = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.k_len = '0; bus.fifo_empty = '0;
        @(posedge clk);
        @(posedge clk);
        doReset();

        // Basic wavefront, start accepted on first edge after reset release.
        checkBasicPattern("pattern031");

        // A lane goes empty at step 2 for three cycles: all lanes freeze.
        pat32 = '{4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
        readLog.delete();
        applyStimulus(1'b1, CW'(3), '0);
        injected = 0;
        for (int c = 0; c < 30 && mState != M_IDLE; c++) begin
            emp = '0;
            if (mState == M_RUN && mIdx == 2 && injected < 3) begin
                emp = 4'b0100;
                injected++;
            end
            applyStimulus(1'b0, '0, emp);
        end
        checkOutput("stallBusyCycles", 32'(busyCycles), 32'(9));
        for (int j = 0; j < 9 && j < readLog.size(); j++) checkOutput("pattern032", 32'(readLog[j]), 32'(pat32[j]));

        // Lane 0 permanently empty: timeout, error, no done; next start clears error.
        applyStimulus(1'b1, CW'(3), 4'b0001);
        runToIdle(4'b0001, 100);
        checkOutput("timeoutStallCycles", 32'(busyCycles), 32'(TO));
        applyStimulus(1'b0, '0, '0);
        checkOutput("errorSticky", 32'(bus.error), 32'(1));
        applyStimulus(1'b1, CW'(2), '0);
        runToIdle('0, 20);

        // Zero-length start ignored; start during a run ignored.
        applyStimulus(1'b1, CW'(0), '0);
        applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, CW'(3), '0);
        applyStimulus(1'b1, CW'(7), '0);
        applyStimulus(1'b1, CW'(9), '0);
        runToIdle('0, 20);
        checkOutput("ignoredStartRunLen", 32'(runCycles), 32'(6));

        // Reset at step 3, then a fresh run must give the full pattern.
        applyStimulus(1'b1, CW'(3), '0);
        for (int c = 0; c < 10 && !(mState == M_RUN && mIdx == 3); c++) applyStimulus(1'b0, '0, '0);
        doReset();
        checkBasicPattern("patternAfterReset");

        // Maximum vector length.
        applyStimulus(1'b1, CW'(31), '0);
        runToIdle('0, 60);
        checkOutput("maxLenRunCycles", 32'(runCycles), 32'(34));

        // Randomised runs with sporadic empties and stray starts.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) applyStimulus(1'b1, CW'(0), '0);
            applyStimulus(1'b1, CW'($urandom_range(1, 31)), '0);
            for (int c = 0; c < 400 && mState != M_IDLE; c++) begin
                emp = '0;
                for (int i = 0; i < N; i++) emp[i] = ($urandom_range(0, 7) == 0);
                applyStimulus(1'($urandom_range(0, 15) == 0), CW'($urandom_range(0, 31)), emp);
            end
            if (mState != M_IDLE) checkOutput("randomRunBound", 32'(bus.busy), 32'(0));
            applyStimulus(1'b0, '0, N'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
